// File: rtl/alu_pkg.sv
// Shared constants for the integer execution unit: opcode fields, ALU op and
// branch funct3 encodings, and the I-type op normalisation helper.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_f3_e;

    // I-type ops carry immediate bits in funct7, so op[3] only means SRA there.
    function automatic logic [3:0] alu_key(input logic [6:0] op_type, input logic [3:0] op);
        logic [3:0] key;
        if ((op_type == OP_I) && (op[2:0] != 3'b101)) begin
            key = {1'b0, op[2:0]};
        end else begin
            key = op;
        end
        return key;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I integer/compare datapath: (type, op, v1, v2) -> result.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [6:0]      alu_type,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] v1,
    input  logic [XLEN-1:0] v2,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt_s;
    logic [3:0] key_s;
    logic       lt_s;
    logic       ltu_s;
    logic       eq_s;

    assign shamt_s = v2[4:0];
    assign key_s   = alu_key(alu_type, alu_op);
    assign lt_s    = $signed(v1) < $signed(v2);
    assign ltu_s   = v1 < v2;
    assign eq_s    = v1 == v2;

    // Result select by opcode class, then by op / branch condition.
    always_comb begin
        result = {XLEN{1'b0}};
        case (alu_type)
            OP_R, OP_I: begin
                case (key_s)
                    ALU_ADD:  result = v1 + v2;
                    ALU_SUB:  result = v1 - v2;
                    ALU_SLL:  result = v1 << shamt_s;
                    ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
                    ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu_s};
                    ALU_XOR:  result = v1 ^ v2;
                    ALU_SRL:  result = v1 >> shamt_s;
                    ALU_SRA:  result = XLEN'($signed(v1) >>> shamt_s);
                    ALU_OR:   result = v1 | v2;
                    ALU_AND:  result = v1 & v2;
                    default:  result = {XLEN{1'b0}};
                endcase
            end
            OP_B: begin
                case (alu_op[2:0])
                    BR_EQ:   result = {{(XLEN-1){1'b0}}, eq_s};
                    BR_NE:   result = {{(XLEN-1){1'b0}}, !eq_s};
                    BR_LT:   result = {{(XLEN-1){1'b0}}, lt_s};
                    BR_GE:   result = {{(XLEN-1){1'b0}}, !lt_s};
                    BR_LTU:  result = {{(XLEN-1){1'b0}}, ltu_s};
                    BR_GEU:  result = {{(XLEN-1){1'b0}}, !ltu_s};
                    default: result = {XLEN{1'b0}};
                endcase
            end
            default: result = v1 + v2;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// ALU execution stage: computes one op per cycle into a result FIFO drained to the CDB.
// Optional macro ALU_BYPASS_EN lets a result skip an empty FIFO straight onto the CDB.
module alu_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            _clear,
    input  logic            _alu_ready,
    input  logic [4:0]      _alu_rob_id,
    input  logic [6:0]      _alu_type,
    input  logic [3:0]      _alu_op,
    input  logic [XLEN-1:0] _alu_v1,
    input  logic [XLEN-1:0] _alu_v2,
    output logic            _alu_full,
    input  logic            _cdb_stall,
    output logic            _cdb_ready,
    output logic [4:0]      _cdb_rob_id,
    output logic [XLEN-1:0] _cdb_value
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]   count_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [4:0]      rob_mem_r [DEPTH];
    logic [XLEN-1:0] val_mem_r [DEPTH];

    logic [XLEN-1:0] result_s;
    logic            accept_s;
    logic            fifo_valid_s;
    logic            bypass_s;
    logic            push_s;
    logic            pop_s;

    alu_core #(.XLEN(XLEN)) u_core (
        .alu_type (_alu_type),
        .alu_op   (_alu_op),
        .v1       (_alu_v1),
        .v2       (_alu_v2),
        .result   (result_s)
    );

    // Full comes from the registered count only; a same-cycle pop gives no credit.
    assign _alu_full = (count_r == CW'(DEPTH));

    // Handshake decode and CDB output mux.
    always_comb begin
        accept_s     = rdy_in && !_clear && _alu_ready && !_alu_full;
        fifo_valid_s = rdy_in && (count_r != {CW{1'b0}});
`ifdef ALU_BYPASS_EN
        bypass_s     = accept_s && (count_r == {CW{1'b0}}) && !_cdb_stall;
`else
        bypass_s     = 1'b0;
`endif
        push_s       = accept_s && !bypass_s;
        pop_s        = fifo_valid_s && !_cdb_stall;
        if (bypass_s) begin
            _cdb_ready  = 1'b1;
            _cdb_rob_id = _alu_rob_id;
            _cdb_value  = result_s;
        end else begin
            _cdb_ready  = fifo_valid_s;
            _cdb_rob_id = rob_mem_r[rd_ptr_r];
            _cdb_value  = val_mem_r[rd_ptr_r];
        end
    end

    // FIFO storage, pointers and occupancy; a flush wins over push/pop.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rob_mem_r[i] <= 5'd0;
                val_mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (rdy_in) begin
            if (_clear) begin
                count_r  <= {CW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    rob_mem_r[wr_ptr_r] <= _alu_rob_id;
                    val_mem_r[wr_ptr_r] <= result_s;
                    wr_ptr_r            <= wr_ptr_r + PW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_unit;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            _clear;
    logic            _alu_ready;
    logic [4:0]      _alu_rob_id;
    logic [6:0]      _alu_type;
    logic [3:0]      _alu_op;
    logic [XLEN-1:0] _alu_v1;
    logic [XLEN-1:0] _alu_v2;
    logic            _alu_full;
    logic            _cdb_stall;
    logic            _cdb_ready;
    logic [4:0]      _cdb_rob_id;
    logic [XLEN-1:0] _cdb_value;

    int vectors     = 0;
    int miscompares = 0;

    logic [36:0] q[$];
    logic        o_rdy, o_full, e_rdy, e_full;
    logic [4:0]  o_rob, e_rob;
    logic [31:0] o_val, e_val;

    alu_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (_clear),
        ._alu_ready  (_alu_ready),
        ._alu_rob_id (_alu_rob_id),
        ._alu_type   (_alu_type),
        ._alu_op     (_alu_op),
        ._alu_v1     (_alu_v1),
        ._alu_v2     (_alu_v2),
        ._alu_full   (_alu_full),
        ._cdb_stall  (_cdb_stall),
        ._cdb_ready  (_cdb_ready),
        ._cdb_rob_id (_cdb_rob_id),
        ._cdb_value  (_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RV32I semantics written from the instruction definitions.
    function automatic logic [31:0] ref_alu(input logic [6:0] t, input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        int signed   sa;
        int signed   sb;
        int unsigned sh;
        bit          alt;
        sa = a;
        sb = b;
        sh = b[4:0];
        if (t == 7'b1100011) begin
            case (op[2:0])
                3'd0:    return (a == b) ? 32'd1 : 32'd0;
                3'd1:    return (a != b) ? 32'd1 : 32'd0;
                3'd4:    return (sa < sb) ? 32'd1 : 32'd0;
                3'd5:    return (sa >= sb) ? 32'd1 : 32'd0;
                3'd6:    return (a < b) ? 32'd1 : 32'd0;
                3'd7:    return (a >= b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        if (t == 7'b0110011 || t == 7'b0010011) begin
            alt = op[3] && (t == 7'b0110011 || op[2:0] == 3'd5);
            case (op[2:0])
                3'd0:    return alt ? a - b : a + b;
                3'd1:    return a << sh;
                3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
                3'd3:    return (a < b) ? 32'd1 : 32'd0;
                3'd4:    return a ^ b;
                3'd5:    return alt ? 32'(sa >>> sh) : a >> sh;
                3'd6:    return a | b;
                default: return a & b;
            endcase
        end
        return a + b;
    endfunction

    task automatic issue(input logic [6:0] t, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rob);
        _alu_ready  = 1'b1;
        _alu_type   = t;
        _alu_op     = op;
        _alu_v1     = a;
        _alu_v2     = b;
        _alu_rob_id = rob;
    endtask

    task automatic idle();
        _alu_ready = 1'b0;
    endtask

    // One clock: sample DUT and model expectations at negedge, then advance the model.
    task automatic tick();
        bit          bypass;
        int          n;
        logic [31:0] res;
        @(negedge clk_in);
        o_rdy  = _cdb_ready;
        o_full = _alu_full;
        o_rob  = _cdb_rob_id;
        o_val  = _cdb_value;
        bypass = 1'b0;
`ifdef ALU_BYPASS_EN
        bypass = rdy_in && !_clear && _alu_ready && (q.size() == 0) && !_cdb_stall;
`endif
        res    = ref_alu(_alu_type, _alu_op, _alu_v1, _alu_v2);
        e_full = (q.size() == DEPTH);
        if (q.size() > 0) begin
            e_rdy = rdy_in;
            {e_rob, e_val} = q[0];
        end else if (bypass) begin
            e_rdy = 1'b1;
            e_rob = _alu_rob_id;
            e_val = res;
        end else begin
            e_rdy = 1'b0;
            e_rob = 5'd0;
            e_val = 32'd0;
        end
        @(posedge clk_in);
        if (rdy_in) begin
            if (_clear) begin
                q.delete();
            end else begin
                n = q.size();
                if (n > 0 && !_cdb_stall) void'(q.pop_front());
                if (_alu_ready && n < DEPTH && !bypass) q.push_back({_alu_rob_id, res});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _cdb_stall = 1'b0;
        _alu_ready = 1'b0; _alu_rob_id = 5'd0; _alu_type = 7'd0; _alu_op = 4'd0;
        _alu_v1 = 32'd0; _alu_v2 = 32'd0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        vectors++;
        if (_cdb_ready !== 1'b0 || _alu_full !== 1'b0 || _cdb_rob_id !== 5'd0 || _cdb_value !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b full=%b rob=%0d val=%h, expected all zero",
                     _cdb_ready, _alu_full, _cdb_rob_id, _cdb_value);
        end
        q.delete();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    task automatic test_add();
        issue(7'b0110011, 4'b0000, 32'd5, 32'd7, 5'd3);
        tick();
`ifndef ALU_BYPASS_EN
        idle();
        tick();
`endif
        vectors++;
        if (o_rdy !== 1'b1 || o_rob !== 5'd3 || o_val !== 32'd12) begin
            miscompares++;
            $display("FAIL add: got rdy=%b rob=%0d val=%0d, expected rdy=1 rob=3 val=12", o_rdy, o_rob, o_val);
        end
        idle();
        tick();
        vectors++;
        if (o_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL add_empty: got rdy=%b, expected 0", o_rdy);
        end
    endtask

    task automatic test_ops();
        logic [6:0]  ts [4] = '{7'b0110011, 7'b0110011, 7'b1100011, 7'b1100011};
        logic [3:0]  ops[4] = '{4'b1101, 4'b0011, 4'b0100, 4'b0111};
        logic [31:0] a  [4] = '{32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] b  [4] = '{32'd4, 32'hFFFF_FFFF, 32'd0, 32'd2};
        logic [31:0] ex [4] = '{32'hF800_0000, 32'd1, 32'd1, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(ts[i], ops[i], a[i], b[i], 5'(i + 20));
            tick();
`ifndef ALU_BYPASS_EN
            idle();
            tick();
`endif
            idle();
            vectors++;
            if (o_rdy !== 1'b1 || o_rob !== 5'(i + 20) || o_val !== ex[i]) begin
                miscompares++;
                $display("FAIL op%0d: got rdy=%b rob=%0d val=%h, expected rdy=1 rob=%0d val=%h",
                         i, o_rdy, o_rob, o_val, i + 20, ex[i]);
            end
        end
        tick();
    endtask

    task automatic test_full();
        _cdb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(7'b0110011, 4'b0000, 32'(i), 32'd100, 5'(10 + i));
            tick();
        end
        idle();
        tick();
        vectors++;
        if (o_full !== 1'b1 || o_rdy !== 1'b1 || o_rob !== 5'd10) begin
            miscompares++;
            $display("FAIL full: got full=%b rdy=%b rob=%0d, expected full=1 rdy=1 rob=10", o_full, o_rdy, o_rob);
        end
        issue(7'b0110011, 4'b0000, 32'd9, 32'd9, 5'd20);
        tick();
        vectors++;
        if (o_full !== 1'b1 || o_rob !== 5'd10) begin
            miscompares++;
            $display("FAIL full_hold: got full=%b rob=%0d, expected full=1 rob=10", o_full, o_rob);
        end
        idle();
        _cdb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (o_rdy !== 1'b1 || o_rob !== 5'(10 + i) || o_val !== 32'(100 + i)) begin
                miscompares++;
                $display("FAIL drain%0d: got rdy=%b rob=%0d val=%0d, expected rdy=1 rob=%0d val=%0d",
                         i, o_rdy, o_rob, o_val, 10 + i, 100 + i);
            end
        end
        tick();
        vectors++;
        if (o_rdy !== 1'b0 || o_full !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got rdy=%b full=%b, expected 0 0", o_rdy, o_full);
        end
    endtask

    task automatic test_clear();
        _cdb_stall = 1'b1;
        issue(7'b0110011, 4'b0000, 32'd1, 32'd1, 5'd1);
        tick();
        issue(7'b0110011, 4'b0000, 32'd2, 32'd2, 5'd2);
        tick();
        issue(7'b0110011, 4'b0000, 32'd3, 32'd3, 5'd5);
        _clear = 1'b1;
        tick();
        vectors++;
        if (o_rdy !== 1'b1 || o_rob !== 5'd1) begin
            miscompares++;
            $display("FAIL clear_head: got rdy=%b rob=%0d, expected rdy=1 rob=1", o_rdy, o_rob);
        end
        _clear = 1'b0;
        _cdb_stall = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (o_rdy !== 1'b0 || o_full !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_empty%0d: got rdy=%b full=%b, expected 0 0", i, o_rdy, o_full);
            end
        end
    endtask

    task automatic test_latency();
        logic first_rdy;
`ifdef ALU_BYPASS_EN
        first_rdy = 1'b1;
`else
        first_rdy = 1'b0;
`endif
        issue(7'b0110011, 4'b0000, 32'd2, 32'd3, 5'd9);
        tick();
        idle();
        vectors++;
        if (o_rdy !== first_rdy || (first_rdy && o_val !== 32'd5)) begin
            miscompares++;
            $display("FAIL lat_same: got rdy=%b val=%0d, expected rdy=%b val=5", o_rdy, o_val, first_rdy);
        end
        tick();
        vectors++;
        if (o_rdy !== !first_rdy || (!first_rdy && o_val !== 32'd5)) begin
            miscompares++;
            $display("FAIL lat_next: got rdy=%b val=%0d, expected rdy=%b val=5", o_rdy, o_val, !first_rdy);
        end
        _cdb_stall = 1'b1;
        issue(7'b0110011, 4'b0000, 32'd2, 32'd3, 5'd9);
        tick();
        idle();
        _cdb_stall = 1'b0;
        vectors++;
        if (o_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_stall: got rdy=%b, expected 0", o_rdy);
        end
        tick();
        vectors++;
        if (o_rdy !== 1'b1 || o_rob !== 5'd9 || o_val !== 32'd5) begin
            miscompares++;
            $display("FAIL lat_release: got rdy=%b rob=%0d val=%0d, expected rdy=1 rob=9 val=5", o_rdy, o_rob, o_val);
        end
        tick();
    endtask

    task automatic test_freeze();
        _cdb_stall = 1'b1;
        issue(7'b0010011, 4'b0100, 32'h0F0F_0F0F, 32'h0000_0FF0, 5'd7);
        tick();
        issue(7'b0110111, 4'b1010, 32'd40, 32'd2, 5'd8);
        tick();
        rdy_in = 1'b0;
        _cdb_stall = 1'b0;
        issue(7'b0110011, 4'b0000, 32'd1, 32'd1, 5'd30);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (o_rdy !== 1'b0 || e_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze%0d: got rdy=%b, expected 0", i, o_rdy);
            end
        end
        rdy_in = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (o_rdy !== e_rdy || (e_rdy && {o_rob, o_val} !== {e_rob, e_val})) begin
                miscompares++;
                $display("FAIL thaw%0d: got rdy=%b rob=%0d val=%h, expected rdy=%b rob=%0d val=%h",
                         i, o_rdy, o_rob, o_val, e_rdy, e_rob, e_val);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] f3;
        int         cls;
        for (int i = 0; i < 600; i++) begin
            rdy_in     = ($urandom_range(0, 9) != 0);
            _clear     = ($urandom_range(0, 19) == 0);
            _cdb_stall = ($urandom_range(0, 2) == 0);
            _alu_ready = ($urandom_range(0, 9) < 6);
            cls = $urandom_range(0, 3);
            f3  = 3'($urandom_range(0, 7));
            _alu_v1     = $urandom;
            _alu_v2     = ($urandom_range(0, 3) == 0) ? _alu_v1 : $urandom;
            _alu_rob_id = 5'($urandom);
            case (cls)
                0: begin
                    _alu_type = 7'b0110011;
                    _alu_op   = {(f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom) : 1'b0, f3};
                end
                1: begin _alu_type = 7'b0010011; _alu_op = 4'($urandom); end
                2: begin _alu_type = 7'b1100011; _alu_op = {1'($urandom), f3}; end
                default: begin _alu_type = 7'b0110111; _alu_op = 4'($urandom); end
            endcase
            tick();
            vectors++;
            if (o_rdy !== e_rdy || o_full !== e_full) begin
                miscompares++;
                $display("FAIL rand%0d_ctl: got rdy=%b full=%b, expected rdy=%b full=%b", i, o_rdy, o_full, e_rdy, e_full);
            end
            if (e_rdy) begin
                vectors++;
                if ({o_rob, o_val} !== {e_rob, e_val}) begin
                    miscompares++;
                    $display("FAIL rand%0d_data: got rob=%0d val=%h, expected rob=%0d val=%h", i, o_rob, o_val, e_rob, e_val);
                end
            end
        end
        rdy_in = 1'b1; _clear = 1'b0; _cdb_stall = 1'b0;
        idle();
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset_midstream();
        _cdb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(7'b0110011, 4'b0110, 32'(i), 32'd8, 5'(i + 1));
            tick();
        end
        idle();
        #2 rst_in = 1'b1;
        #1;
        vectors++;
        if (_cdb_ready !== 1'b0 || _alu_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got rdy=%b full=%b, expected 0 0", _cdb_ready, _alu_full);
        end
        q.delete();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        _cdb_stall = 1'b0;
        tick();
        vectors++;
        if (o_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got rdy=%b, expected 0", o_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_full();
        test_clear();
        test_latency();
        test_freeze();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
